// File: rtl/pulse_gen_n.sv
// Multi-channel counted pulse generator: each channel emits a one-shot pulse or a periodic
// train with programmable high/low lengths in clock cycles.
module pulse_gen_n #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] start_i,
    input  logic [CHANNELS-1:0] stop_i,
    input  logic                mode_i,
    input  logic [CNT_W-1:0]    width_i,
    input  logic [CNT_W-1:0]    gap_i,
    output logic [CHANNELS-1:0] pulse_o,
    output logic [CHANNELS-1:0] busy_o,
    output logic [CHANNELS-1:0] done_o
);

    typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        state_e           state_q;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] width_q;
        logic [CNT_W-1:0] gap_q;
        logic             mode_q;
        logic             pulse_q;
        logic             done_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                width_q <= '0;
                gap_q   <= '0;
                mode_q  <= 1'b0;
                pulse_q <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                done_q <= 1'b0;
                unique case (state_q)
                    StIdle: begin
                        // stop beats a simultaneous start; a zero width is never accepted
                        if (start_i[i] && !stop_i[i] && (width_i != '0)) begin
                            mode_q  <= mode_i;
                            width_q <= width_i;
                            gap_q   <= gap_i;
                            cnt_q   <= width_i;
                            state_q <= StHigh;
                            pulse_q <= 1'b1;
                        end
                    end
                    StHigh: begin
                        if (stop_i[i]) begin
                            state_q <= StIdle;
                            pulse_q <= 1'b0;
                        end else if (cnt_q == CntOne) begin
                            pulse_q <= 1'b0;
                            if (mode_q) begin
                                cnt_q   <= (gap_q == '0) ? CntOne : gap_q;
                                state_q <= StLow;
                            end else begin
                                state_q <= StIdle;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q - CntOne;
                        end
                    end
                    StLow: begin
                        if (stop_i[i]) begin
                            state_q <= StIdle;
                        end else if (cnt_q == CntOne) begin
                            cnt_q   <= width_q;
                            state_q <= StHigh;
                            pulse_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - CntOne;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        pulse_q <= 1'b0;
                    end
                endcase
            end
        end

        assign pulse_o[i] = pulse_q;
        assign busy_o[i]  = (state_q != StIdle);
        assign done_o[i]  = done_q;
    end

endmodule

// File: tb/tb_pulse_gen_n.sv
// Scoreboard bench for pulse_gen_n: a per-channel cycle model predicts every output vector,
// and directed sequences add fixed-value checks on the specified corner cases.
module tb_pulse_gen_n;

    localparam int unsigned CH = 4;
    localparam int unsigned W  = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] start, stop;
    logic          mode;
    logic [W-1:0]  width, gap;
    logic [CH-1:0] pulse, busy, done;

    pulse_gen_n #(.CHANNELS(CH), .CNT_W(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start_i(start),
        .stop_i (stop),
        .mode_i (mode),
        .width_i(width),
        .gap_i  (gap),
        .pulse_o(pulse),
        .busy_o (busy),
        .done_o (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state
    int            m_st  [CH];  // 0 idle, 1 high, 2 low
    int            m_cnt [CH];
    int            m_w   [CH];
    int            m_g   [CH];
    logic          m_mode[CH];
    logic [CH-1:0] m_done;
    logic [3*CH-1:0] exp_q[$];
    logic [CH-1:0] obs_pulse, obs_busy, obs_done;

    function automatic logic [3*CH-1:0] model_step();
        logic [CH-1:0] p, b;
        for (int i = 0; i < CH; i++) begin
            if (reset) begin
                m_st[i] = 0; m_cnt[i] = 0; m_done[i] = 1'b0;
            end else begin
                m_done[i] = 1'b0;
                case (m_st[i])
                    0: if (start[i] && !stop[i] && width != 0) begin
                        m_mode[i] = mode; m_w[i] = int'(width); m_g[i] = int'(gap);
                        m_cnt[i] = int'(width); m_st[i] = 1;
                    end
                    1: if (stop[i]) m_st[i] = 0;
                       else if (m_cnt[i] == 1) begin
                           if (m_mode[i]) begin
                               m_cnt[i] = (m_g[i] == 0) ? 1 : m_g[i]; m_st[i] = 2;
                           end else begin
                               m_st[i] = 0; m_done[i] = 1'b1;
                           end
                       end else m_cnt[i]--;
                    default: if (stop[i]) m_st[i] = 0;
                       else if (m_cnt[i] == 1) begin
                           m_cnt[i] = m_w[i]; m_st[i] = 1;
                       end else m_cnt[i]--;
                endcase
            end
            p[i] = (m_st[i] == 1);
            b[i] = (m_st[i] != 0);
        end
        return {p, b, m_done};
    endfunction

    // Push the prediction for the current inputs, clock, then pop and compare.
    task automatic step();
        logic [3*CH-1:0] e;
        exp_q.push_back(model_step());
        @(posedge clk);
        #1;
        obs_pulse = pulse; obs_busy = busy; obs_done = done;
        if (exp_q.size() == 0) begin
            check_eq("sb_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_eq("sb_pulse", 32'(pulse), 32'(e[3*CH-1:2*CH]));
            check_eq("sb_busy",  32'(busy),  32'(e[2*CH-1:CH]));
            check_eq("sb_done",  32'(done),  32'(e[CH-1:0]));
        end
    endtask

    task automatic idle_in();
        reset = 1'b0; start = '0; stop = '0; mode = 1'b0; width = '0; gap = '0;
    endtask

    initial begin
        int hi_cnt, dn_cnt, k;
        bit found;
        idle_in();
        for (int i = 0; i < CH; i++) begin
            m_st[i] = 0; m_cnt[i] = 0; m_w[i] = 0; m_g[i] = 0; m_mode[i] = 1'b0;
        end
        m_done = '0;

        // Reset held with start asserted on every channel
        reset = 1'b1; start = '1; width = 8'd5;
        for (int c = 0; c < 3; c++) begin
            step();
            check_eq("rst_out", 32'({obs_pulse, obs_busy, obs_done}), 32'd0);
        end
        idle_in();
        step();
        check_eq("rst_after", 32'({obs_pulse, obs_busy, obs_done}), 32'd0);
        repeat (5) step();

        // One-shot width 3 on channel 0
        start = 4'b0001; mode = 1'b0; width = 8'd3;
        step();
        idle_in();
        check_eq("os_p1", 32'(obs_pulse), 32'h1);
        step(); check_eq("os_p2", 32'(obs_pulse), 32'h1);
        step(); check_eq("os_p3", 32'(obs_pulse), 32'h1);
        step();
        check_eq("os_done", 32'(obs_done), 32'h1);
        check_eq("os_busy", 32'(obs_busy), 32'h0);
        check_eq("os_pend", 32'(obs_pulse), 32'h0);
        step(); check_eq("os_done1", 32'(obs_done), 32'h0);

        // Periodic width 2 gap 5 on channel 1: 1,1,0,0,0,0,0
        start = 4'b0010; mode = 1'b1; width = 8'd2; gap = 8'd5;
        for (int c = 0; c < 50; c++) begin
            step();
            if (c == 0) idle_in();
            check_eq("per_pat", 32'(obs_pulse[1]), 32'((c % 7) < 2));
            check_eq("per_done", 32'(obs_done[1]), 32'd0);
        end
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            if (obs_pulse[1]) found = 1; else step();
        end
        check_eq("per_align", 32'(found), 32'd1);
        stop = 4'b0010;
        step();
        stop = '0;
        check_eq("stop_pulse", 32'(obs_pulse[1]), 32'd0);
        check_eq("stop_busy", 32'(obs_busy[1]), 32'd0);
        check_eq("stop_done", 32'(obs_done[1]), 32'd0);
        step();

        // Width 0 is ignored
        start = 4'b0100; width = 8'd0;
        step(); idle_in();
        check_eq("w0_busy", 32'(obs_busy), 32'd0);
        step(); check_eq("w0_pulse", 32'(obs_pulse), 32'd0);

        // Periodic gap 0 width 1 on channel 3: 1,0 repeating
        start = 4'b1000; mode = 1'b1; width = 8'd1; gap = 8'd0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (c == 0) idle_in();
            check_eq("g0_pat", 32'(obs_pulse[3]), 32'((c % 2) == 0));
        end
        stop = 4'b1000; step(); idle_in(); step();

        // Max width one-shot on channel 0
        start = 4'b0001; mode = 1'b0; width = 8'd255;
        hi_cnt = 0; dn_cnt = 0;
        for (int c = 0; c < 260; c++) begin
            step();
            if (c == 0) idle_in();
            hi_cnt += int'(obs_pulse[0]);
            dn_cnt += int'(obs_done[0]);
        end
        check_eq("w255_hi", 32'(hi_cnt), 32'd255);
        check_eq("w255_done", 32'(dn_cnt), 32'd1);

        // Start with stop in idle
        start = 4'b0010; stop = 4'b0010; width = 8'd4;
        step(); idle_in();
        check_eq("ss_busy", 32'(obs_busy[1]), 32'd0);

        // Restart while busy keeps original width
        start = 4'b0100; mode = 1'b0; width = 8'd4;
        step();
        width = 8'd9;
        hi_cnt = int'(obs_pulse[2]);
        for (int c = 0; c < 14; c++) begin
            step();
            if (c == 2) idle_in();
            hi_cnt += int'(obs_pulse[2]);
        end
        check_eq("restart_w", 32'(hi_cnt), 32'd4);

        // Held start, one-shot width 2: 1,1,0 repeating
        start = 4'b0001; mode = 1'b0; width = 8'd2;
        for (int c = 0; c < 12; c++) begin
            step();
            check_eq("held_pat", 32'(obs_pulse[0]), 32'((c % 3) < 2));
        end
        idle_in(); repeat (4) step();

        // Reset during periodic LOW (ch2) and one-shot HIGH (ch3)
        start = 4'b0100; mode = 1'b1; width = 8'd2; gap = 8'd5;
        step(); idle_in();
        start = 4'b1000; mode = 1'b0; width = 8'd10;
        step(); idle_in();
        step();
        check_eq("mid_state", 32'({obs_pulse[3:2], obs_busy[3:2]}), 32'b1011);
        reset = 1'b1;
        step(); reset = 1'b0;
        check_eq("mid_rst", 32'({obs_pulse, obs_busy, obs_done}), 32'd0);
        step();
        check_eq("mid_nodone", 32'(obs_done), 32'd0);

        // Random traffic against the model
        for (int c = 0; c < 2000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            start = CH'($urandom) & CH'($urandom);
            for (int i = 0; i < CH; i++) stop[i] = ($urandom_range(0, 15) == 0);
            mode  = 1'($urandom);
            width = W'($urandom_range(0, 12));
            gap   = W'($urandom_range(0, 6));
            step();
        end
        idle_in();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
